mig_seq_eval: RTL

MIG_SEQ_EVAL -- requirements
Module: mig_seq_eval

---
 rtl/mig_seq_eval.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/mig_seq_eval.sv
// mig_seq_eval: sequential majority-inverter graph evaluator.
// A small program memory holds up to N_NODES majority nodes. One shared
// 3-input majority unit evaluates one node per cycle into the node registers.
// After the last node, the selected output signal is presented on a
// valid/ready handshake.
// Optional feature: define MIG_SEQ_CYCLE_CNT_EN to add eval_cnt, a 16-bit
// saturating count of EVAL-state cycles.
module mig_seq_eval #(
  parameter int N_NODES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [14:0] cfg_data,
  input  logic [3:0]  cfg_len,
  input  logic [3:0]  out_sel,
  input  logic        out_inv,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        y
`ifdef MIG_SEQ_CYCLE_CNT_EN
  ,
  output logic [15:0] eval_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [2:0]         idx_r;
  logic [N_NODES-1:0] n_r;
  logic [14:0]        prog_r [N_NODES];
  logic [3:0]         x_r;
  logic [3:0]         len_r;
  logic [3:0]         sel_r;
  logic               inv_r;
  logic               out_valid_r;
  logic               y_r;

  // A write that lands on the acceptance edge is parked here and committed
  // when the transaction finishes, so the evaluation sees the old program.
  logic               pend_v_r;
  logic [2:0]         pend_addr_r;
  logic [14:0]        pend_data_r;

  logic               in_ready_s;
  logic               accept_s;
  logic               last_s;
  logic [3:0]         len_eff_s;
  logic [14:0]        word_s;
  logic               op_a_s;
  logic               op_b_s;
  logic               op_c_s;
  logic               maj_s;
  logic [N_NODES-1:0] n_upd_s;
  logic               y_nxt_s;

  // Operand select decode: 0 and 13..15 are constant 0, 1..4 the latched
  // inputs, 5..12 the node registers.
  function automatic logic sel_decode(input logic [3:0]         sel,
                                      input logic [3:0]         xv,
                                      input logic [N_NODES-1:0] nv);
    logic v;
    v = 1'b0;
    case (sel)
      4'd1:    v = xv[0];
      4'd2:    v = xv[1];
      4'd3:    v = xv[2];
      4'd4:    v = xv[3];
      4'd5:    v = nv[0];
      4'd6:    v = nv[1];
      4'd7:    v = nv[2];
      4'd8:    v = nv[3];
      4'd9:    v = nv[4];
      4'd10:   v = nv[5];
      4'd11:   v = nv[6];
      4'd12:   v = nv[7];
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Operand fetch, shared majority evaluation and the next output value.
  always_comb begin
    word_s  = prog_r[idx_r];
    op_a_s  = sel_decode(word_s[3:0],   x_r, n_r) ^ word_s[4];
    op_b_s  = sel_decode(word_s[8:5],   x_r, n_r) ^ word_s[9];
    op_c_s  = sel_decode(word_s[13:10], x_r, n_r) ^ word_s[14];
    maj_s   = maj3(op_a_s, op_b_s, op_c_s);
    n_upd_s = n_r;
    n_upd_s[idx_r] = maj_s;
    // y is captured on the last EVAL edge, so it must see the node being written.
    y_nxt_s = sel_decode(sel_r, x_r, n_upd_s) ^ inv_r;
    if ((len_r == 4'd0) || (len_r > 4'd8)) begin
      len_eff_s = 4'd8;
    end else begin
      len_eff_s = len_r;
    end
    last_s = ({1'b0, idx_r} == (len_eff_s - 4'd1));
  end

  // Next-state logic and input handshake.
  always_comb begin
    state_nxt_s = state_r;
    in_ready_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (rst) begin
          in_ready_s = 1'b0;
        end else begin
          in_ready_s = 1'b1;
        end
        if (in_valid && in_ready_s) begin
          state_nxt_s = EVAL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EVAL: begin
        if (last_s) begin
          state_nxt_s = OUT;
        end else begin
          state_nxt_s = EVAL;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OUT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  assign accept_s  = in_valid & in_ready_s;
  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign y         = y_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: input latch, node writes, program memory and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r       <= 3'd0;
      n_r         <= '0;
      x_r         <= 4'd0;
      len_r       <= 4'd0;
      sel_r       <= 4'd0;
      inv_r       <= 1'b0;
      out_valid_r <= 1'b0;
      y_r         <= 1'b0;
      pend_v_r    <= 1'b0;
      pend_addr_r <= 3'd0;
      pend_data_r <= 15'd0;
      for (int i = 0; i < N_NODES; i++) begin
        prog_r[i] <= 15'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            x_r   <= x;
            len_r <= cfg_len;
            sel_r <= out_sel;
            inv_r <= out_inv;
            idx_r <= 3'd0;
          end
          if (cfg_we && accept_s) begin
            pend_v_r    <= 1'b1;
            pend_addr_r <= cfg_addr;
            pend_data_r <= cfg_data;
          end else if (cfg_we) begin
            prog_r[cfg_addr] <= cfg_data;
          end
        end
        EVAL: begin
          n_r   <= n_upd_s;
          idx_r <= idx_r + 3'd1;
          if (last_s) begin
            out_valid_r <= 1'b1;
            y_r         <= y_nxt_s;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            y_r         <= 1'b0;
            if (pend_v_r) begin
              prog_r[pend_addr_r] <= pend_data_r;
              pend_v_r            <= 1'b0;
            end
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef MIG_SEQ_CYCLE_CNT_EN
  logic [15:0] eval_cnt_r;

  // Saturating count of cycles spent in EVAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      eval_cnt_r <= 16'd0;
    end else if ((state_r == EVAL) && (eval_cnt_r != 16'hFFFF)) begin
      eval_cnt_r <= eval_cnt_r + 16'd1;
    end
  end

  assign eval_cnt = eval_cnt_r;
`endif

endmodule
